// File: rtl/simm_dram_pkg.sv
// rtl/simm_dram_pkg.sv - shared state encoding and helpers for the SIMM DRAM controller
package simm_dram_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ROW      = 3'd1;
  localparam state_t ST_COL      = 3'd2;
  localparam state_t ST_ACK      = 3'd3;
  localparam state_t ST_REF_CAS  = 3'd4;
  localparam state_t ST_REF_RAS  = 3'd5;
  localparam state_t ST_REF_HOLD = 3'd6;

  // Width of a bank index; a single-bank build still carries one bit.
  function automatic int bank_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// rtl/dram_refresh_timer.sv - free-running refresh interval counter with sticky request
module dram_refresh_timer #(
  parameter int REFRESH_CNT = 300
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  output logic ref_req_o
);

  localparam int CW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          expire;

  assign expire = (cnt_q == CW'(REFRESH_CNT - 1));

  // The request is visible on the expiry edge itself so an access arriving
  // on that same edge loses to refresh; a new expiry beats a simultaneous clear.
  assign ref_req_o = pend_q | expire;

  // Next-state: wrap the counter, set/clear the sticky pending flag.
  always_comb begin
    cnt_d  = expire ? '0 : cnt_q + CW'(1);
    pend_d = expire | (pend_q & ~clr_i);
  end

  // Counter and pending registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/simm_dram_ctrl.sv
// rtl/simm_dram_ctrl.sv - parametrised FPM/EDO SIMM controller for the 68000 bus
module simm_dram_ctrl
  import simm_dram_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'h100000,
  parameter int          ROW_BITS    = 11,
  parameter int          COL_BITS    = 11,
  parameter int          BANKS       = 2,
  parameter int          T_RCD       = 2,
  parameter int          T_CAS       = 1,
  parameter int          T_RP        = 2,
  parameter int          REFRESH_CNT = 300
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                AS,
  input  logic                UDS,
  input  logic                LDS,
  input  logic                RW,
  input  logic [23:0]         ADDR_IN,
  output logic [ROW_BITS-1:0] ADDR_OUT,
  output logic [BANKS-1:0]    RAS,
  output logic                CAS_UPPER,
  output logic                CAS_LOWER,
  output logic                WE,
  output logic                OE,
  output logic                DTACK_DRAM,
  output logic                REFRESHING
);

  localparam int BW   = bank_w(BANKS);
  localparam int WMAX = (T_RCD > T_CAS) ? T_RCD : T_CAS;
  localparam int WCW  = $clog2(WMAX + 1);
  localparam int PW   = $clog2(T_RP + 1);

  localparam logic [32:0] WIN_LO = {9'd0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(BANKS) << (ROW_BITS + COL_BITS + 1));

  state_t              state_q, state_d;
  logic [WCW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [BW-1:0]       bank_q, bank_d;
  logic [BANKS-1:0]    ras_q, ras_d;
  logic                cas_u_q, cas_u_d;
  logic                cas_l_q, cas_l_d;
  logic                we_q, we_d;
  logic                dtack_q, dtack_d;
  logic                refr_q, refr_d;
  logic [ROW_BITS-1:0] addr_q, addr_d;

  logic                ref_req, ref_clr, pre_done, go_idle, sel;
  logic [32:0]         addr_ext;
  logic [23:0]         off;
  logic [ROW_BITS-1:0] row_addr, col_addr;
  logic [BW-1:0]       bank_sel;
  logic                unused_off;

  // Row/column/bank are taken window-relative so the first DRAM byte is row 0, col 0.
  assign addr_ext   = {9'd0, ADDR_IN};
  assign off        = ADDR_IN - BASE_ADDR;
  assign sel        = ~AS & (addr_ext >= WIN_LO) & (addr_ext < WIN_HI);
  assign col_addr   = ROW_BITS'(off[1 +: COL_BITS]);
  assign row_addr   = off[COL_BITS + 1 +: ROW_BITS];
  assign bank_sel   = BW'(off >> (ROW_BITS + COL_BITS + 1)) & BW'(BANKS - 1);
  assign unused_off = ^off;
  assign pre_done   = (pre_q == '0);

  assign ADDR_OUT   = addr_q;
  assign RAS        = ras_q;
  assign CAS_UPPER  = cas_u_q;
  assign CAS_LOWER  = cas_l_q;
  assign WE         = we_q;
  assign OE         = 1'b0;
  assign DTACK_DRAM = dtack_q;
  assign REFRESHING = refr_q;

  dram_refresh_timer #(
    .REFRESH_CNT(REFRESH_CNT)
  ) u_refresh (
    .CLK      (CLK),
    .RST      (RST),
    .clr_i    (ref_clr),
    .ref_req_o(ref_req)
  );

  // Access/refresh sequencer: each state's actions take effect on the edge spent in it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    ras_d   = ras_q;
    cas_u_d = cas_u_q;
    cas_l_d = cas_l_q;
    we_d    = we_q;
    dtack_d = dtack_q;
    addr_d  = addr_q;
    refr_d  = refr_q;
    ref_clr = 1'b0;
    go_idle = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ref_req && pre_done) begin
          state_d = ST_REF_CAS;
        end else if (sel && pre_done) begin
          addr_d  = row_addr;
          we_d    = RW;
          bank_d  = bank_sel;
          state_d = ST_ROW;
        end
      end
      ST_ROW: begin
        if (AS) begin
          go_idle = 1'b1;
        end else begin
          ras_d[bank_q] = 1'b0;
          if (cnt_q == WCW'(T_RCD - 1)) begin
            addr_d  = col_addr;
            cnt_d   = '0;
            state_d = ST_COL;
          end else begin
            cnt_d = cnt_q + WCW'(1);
          end
        end
      end
      ST_COL: begin
        if (AS) begin
          go_idle = 1'b1;
        end else begin
          if (cnt_q == '0) begin
            cas_u_d = UDS;
            cas_l_d = LDS;
          end
          if (cnt_q == WCW'(T_CAS)) begin
            dtack_d = 1'b0;
            cnt_d   = '0;
            state_d = ST_ACK;
          end else begin
            cnt_d = cnt_q + WCW'(1);
          end
        end
      end
      ST_ACK: begin
        if (AS) go_idle = 1'b1;
      end
      ST_REF_CAS: begin
        refr_d  = 1'b1;
        we_d    = 1'b1;
        cas_u_d = 1'b0;
        cas_l_d = 1'b0;
        state_d = ST_REF_RAS;
      end
      ST_REF_RAS: begin
        ras_d   = '0;
        ref_clr = 1'b1;
        cnt_d   = '0;
        state_d = ST_REF_HOLD;
      end
      ST_REF_HOLD: begin
        if (cnt_q == WCW'(T_RCD - 1)) begin
          ras_d   = '1;
          cas_u_d = 1'b1;
          cas_l_d = 1'b1;
          refr_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + WCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_idle) begin
      ras_d   = '1;
      cas_u_d = 1'b1;
      cas_l_d = 1'b1;
      we_d    = 1'b1;
      dtack_d = 1'b1;
      addr_d  = '0;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end
  end

  // Precharge: any RAS rising restarts the count; it then drains to zero.
  always_comb begin
    if (|(~ras_q & ras_d)) pre_d = PW'(T_RP);
    else if (!pre_done)    pre_d = pre_q - PW'(1);
    else                   pre_d = pre_q;
  end

  // State and registered DRAM-side outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pre_q   <= PW'(T_RP);
      bank_q  <= '0;
      ras_q   <= '1;
      cas_u_q <= 1'b1;
      cas_l_q <= 1'b1;
      we_q    <= 1'b1;
      dtack_q <= 1'b1;
      refr_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      bank_q  <= bank_d;
      ras_q   <= ras_d;
      cas_u_q <= cas_u_d;
      cas_l_q <= cas_l_d;
      we_q    <= we_d;
      dtack_q <= dtack_d;
      refr_q  <= refr_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_simm_dram_ctrl.sv
// tb/tb_simm_dram_ctrl.sv - directed self-checking bench for simm_dram_ctrl
module tb_simm_dram_ctrl;
  import simm_dram_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        AS = 1'b1, UDS = 1'b1, LDS = 1'b1, RW = 1'b1;
  logic [23:0] ADDR_IN = '0;

  logic [10:0] ADDR_OUT, addr2;
  logic [1:0]  RAS, ras2;
  logic        CAS_UPPER, CAS_LOWER, WE, OE, DTACK_DRAM, REFRESHING;
  logic        casu2, casl2, we2, oe2, dtack2, refr2;

  int n_cmp = 0;
  int n_bad = 0;
  int lat1, lat2, rf2, cf2, gap1, gap2;

  simm_dram_ctrl #(.ROW_BITS(11), .COL_BITS(10)) dut (
    .CLK(CLK), .RST(RST), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .ADDR_IN(ADDR_IN),
    .ADDR_OUT(ADDR_OUT), .RAS(RAS), .CAS_UPPER(CAS_UPPER), .CAS_LOWER(CAS_LOWER),
    .WE(WE), .OE(OE), .DTACK_DRAM(DTACK_DRAM), .REFRESHING(REFRESHING)
  );

  simm_dram_ctrl #(.ROW_BITS(11), .COL_BITS(10), .T_RCD(3), .T_RP(4)) dut2 (
    .CLK(CLK), .RST(RST), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .ADDR_IN(ADDR_IN),
    .ADDR_OUT(addr2), .RAS(ras2), .CAS_UPPER(casu2), .CAS_LOWER(casl2),
    .WE(we2), .OE(oe2), .DTACK_DRAM(dtack2), .REFRESHING(refr2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mk(input logic [1:0] r, input logic cu, input logic cl,
                                     input logic we, input logic dt, input logic rf,
                                     input logic [10:0] a);
    return {14'd0, r, cu, cl, we, dt, rf, a};
  endfunction

  function automatic logic [31:0] ovec();
    return {14'd0, RAS, CAS_UPPER, CAS_LOWER, WE, DTACK_DRAM, REFRESHING, ADDR_OUT};
  endfunction

  localparam logic [31:0] IDLE_V = {14'd0, 2'b11, 4'b1111, 1'b0, 11'd0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1; ADDR_IN = '0;
    tick(2);
    RST = 1'b1;
  endtask

  task automatic start(input logic [23:0] a, input logic rw, input logic u, input logic l);
    ADDR_IN = a; RW = rw; UDS = u; LDS = l; AS = 1'b0;
  endtask

  task automatic finish_cycle();
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    RST = 1'b0;
    tick(2);
    check("reset_outputs", ovec(), IDLE_V);
    check("reset_oe", {31'd0, OE}, 32'd0);
    check("reset_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
    RST = 1'b1;
    tick(4);

    // Word read at window base
    start(24'h100000, 1'b1, 1'b0, 1'b0);
    tick(1); check("rd_e1_row", ovec(), mk(2'b11, 1, 1, 1, 1, 0, 11'd0));
    tick(1); check("rd_e2_ras", ovec(), mk(2'b10, 1, 1, 1, 1, 0, 11'd0));
    tick(1); check("rd_e3_col", ovec(), mk(2'b10, 1, 1, 1, 1, 0, 11'd0));
    tick(1); check("rd_e4_cas", ovec(), mk(2'b10, 0, 0, 1, 1, 0, 11'd0));
    tick(1); check("rd_e5_dtack", ovec(), mk(2'b10, 0, 0, 1, 0, 0, 11'd0));
    finish_cycle();
    tick(1); check("rd_release", ovec(), IDLE_V);
    tick(3);

    // Low-byte write, bank 1, column 1
    start(24'h500003, 1'b0, 1'b1, 1'b0);
    tick(1); check("wr_e1_we", ovec(), mk(2'b11, 1, 1, 0, 1, 0, 11'd0));
    tick(1); check("wr_e2_ras1", ovec(), mk(2'b01, 1, 1, 0, 1, 0, 11'd0));
    tick(1); check("wr_e3_col", ovec(), mk(2'b01, 1, 1, 0, 1, 0, 11'd1));
    tick(1); check("wr_e4_casl", ovec(), mk(2'b01, 1, 0, 0, 1, 0, 11'd1));
    tick(1); check("wr_e5_dtack", ovec(), mk(2'b01, 1, 0, 0, 0, 0, 11'd1));
    finish_cycle();
    tick(1); check("wr_release", ovec(), IDLE_V);
    tick(3);

    // Accesses just below and just above the window
    start(24'h0FFFFE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1); check("unsel_below", ovec(), IDLE_V);
    end
    finish_cycle(); tick(1);
    start(24'h900000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1); check("unsel_above", ovec(), IDLE_V);
    end
    finish_cycle(); tick(1);

    // Refresh expiry on the same edge an access is first seen
    do_reset();
    tick(299);
    start(24'h100000, 1'b1, 1'b0, 1'b0);
    tick(1); check("ref_300_idle", ovec(), IDLE_V);
    tick(1); check("ref_301_cas", ovec(), mk(2'b11, 0, 0, 1, 1, 1, 11'd0));
    tick(1); check("ref_302_ras", ovec(), mk(2'b00, 0, 0, 1, 1, 1, 11'd0));
    tick(1); check("ref_303_hold", ovec(), mk(2'b00, 0, 0, 1, 1, 1, 11'd0));
    tick(1); check("ref_304_end", ovec(), IDLE_V);
    tick(1); check("ref_305_prechg", ovec(), IDLE_V);
    tick(1); check("ref_306_prechg", ovec(), IDLE_V);
    tick(1); check("ref_307_row", ovec(), IDLE_V);
    tick(1); check("ref_308_ras", ovec(), mk(2'b10, 1, 1, 1, 1, 0, 11'd0));
    tick(1); check("ref_309_col", ovec(), mk(2'b10, 1, 1, 1, 1, 0, 11'd0));
    tick(1); check("ref_310_cas", ovec(), mk(2'b10, 0, 0, 1, 1, 0, 11'd0));
    tick(1); check("ref_311_dtack", ovec(), mk(2'b10, 0, 0, 1, 0, 0, 11'd0));
    finish_cycle(); tick(1);

    // Latency and back-to-back precharge, default and T_RCD=3/T_RP=4
    do_reset();
    tick(6);
    lat1 = 0; lat2 = 0; rf2 = 0; cf2 = 0;
    start(24'h100000, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (lat1 == 0 && DTACK_DRAM == 1'b0) lat1 = k;
      if (lat2 == 0 && dtack2 == 1'b0) lat2 = k;
      if (rf2 == 0 && ras2 != 2'b11) rf2 = k;
      if (cf2 == 0 && casu2 == 1'b0) cf2 = k;
    end
    check("latency_default", lat1, 5);
    check("latency_rcd3", lat2, 6);
    check("rcd3_ras_to_cas", cf2 - rf2, 3);
    AS = 1'b1;
    tick(1);
    check("b2b_release_def", {30'd0, RAS}, {30'd0, 2'b11});
    check("b2b_release_rcd3", {30'd0, ras2}, {30'd0, 2'b11});
    AS = 1'b0;
    gap1 = 0; gap2 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (gap1 == 0 && RAS != 2'b11) gap1 = k;
      if (gap2 == 0 && ras2 != 2'b11) gap2 = k;
    end
    check("b2b_gap_trp2", gap1, 4);
    check("b2b_gap_trp4", gap2, 6);
    finish_cycle(); tick(1);

    // Abort while in ROW
    do_reset();
    tick(4);
    start(24'h100000, 1'b1, 1'b0, 1'b0);
    tick(2); check("abort_ras_low", ovec(), mk(2'b10, 1, 1, 1, 1, 0, 11'd0));
    AS = 1'b1;
    tick(1); check("abort_release", ovec(), IDLE_V);
    check("abort_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
    tick(4); check("abort_no_dtack", ovec(), IDLE_V);

    // Reset while holding ACK
    start(24'h100000, 1'b1, 1'b0, 1'b0);
    tick(5); check("rstack_dtack", ovec(), mk(2'b10, 0, 0, 1, 0, 0, 11'd0));
    tick(2);
    RST = 1'b0;
    tick(1); check("rstack_outputs", ovec(), IDLE_V);
    check("rstack_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
    RST = 1'b1;
    finish_cycle(); tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
